// File: rtl/bitnet_seq_pkg.sv
// Shared types and constants for the training-pass sequencer.
// Holds the FSM state encoding and the oscillator LFSR seed and taps.
package bitnet_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FWD,
      CAPT,
      BWD,
      DONE
   } seq_state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11: taps at bits 0,2,3,5
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; one step per enabled cycle, output is bit 0.
// Deliberately has no reset so it keeps stepping while the array is held in reset.
module lfsr16
   import bitnet_seq_pkg::*;
(
   input  logic clk_in,
   input  logic en,
   output logic lfsr_bit
);

   logic [15:0] lfsr_q = LFSR_SEED;

   always_ff @(posedge clk_in) begin
      if (en) begin
         lfsr_q <= {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
      end
   end

   assign lfsr_bit = lfsr_q[0];

endmodule

// File: rtl/prop_sequencer.sv
// Drives one sample through a DEPTH-layer array: forward strobes, capture, optional backward strobes.
// Result valid DEPTH+2 (inference) or 2*DEPTH+2 (train) cycles after accept; held until res_ready.
module prop_sequencer
   import bitnet_seq_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       sample_valid,
   output logic                       sample_ready,
   input  logic [WIDTH-1:0]           sample_in,
   input  logic [WIDTH-1:0]           sample_tgt,
   input  logic                       train_en,
   output logic [WIDTH-1:0]           net_fin,
   input  logic [WIDTH-1:0]           net_fout,
   output logic [WIDTH-1:0]           net_bin,
   output logic [DEPTH-1:0]           fd_prop,
   output logic [DEPTH-1:0]           bk_prop,
   output logic                       oscillator,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [WIDTH-1:0]           res_out,
   output logic [$clog2(WIDTH+1)-1:0] res_errs
);

   localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int ERR_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] tgt_q;
   logic [WIDTH-1:0] err_vec;
   logic [ERR_W-1:0] err_cnt;
   logic             train_q;
   logic             accept;

   lfsr16 u_lfsr (
      .clk_in   (clk_in),
      .en       (1'b1),
      .lfsr_bit (oscillator)
   );

   // Ready is masked by reset so the host never sees a handshake that reset will discard
   assign sample_ready = (state_q == IDLE) && !rst_in;
   assign accept       = sample_valid && sample_ready;
   assign res_valid    = (state_q == DONE);
   assign err_vec      = net_fout ^ tgt_q;

   always_comb begin
      err_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         err_cnt = err_cnt + ERR_W'(err_vec[i]);
      end
   end

   always_comb begin
      state_d = state_q;
      fd_prop = '0;
      bk_prop = '0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = FWD;
         end
         FWD: begin
            fd_prop = DEPTH'(1) << cnt_q;
            if (cnt_q == LAST) state_d = CAPT;
         end
         CAPT: begin
            state_d = train_q ? BWD : DONE;
         end
         BWD: begin
            bk_prop = DEPTH'(1) << cnt_q;
            if (cnt_q == '0) state_d = DONE;
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         net_fin  <= '0;
         tgt_q    <= '0;
         train_q  <= 1'b0;
         net_bin  <= '0;
         res_out  <= '0;
         res_errs <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  net_fin <= sample_in;
                  tgt_q   <= sample_tgt;
                  train_q <= train_en;
                  cnt_q   <= '0;
               end
            end
            FWD: begin
               if (cnt_q != LAST) cnt_q <= cnt_q + CNT_W'(1);
            end
            CAPT: begin
               res_out  <= net_fout;
               net_bin  <= err_vec;
               res_errs <= err_cnt;
               // Backward pass walks from the last layer down
               cnt_q    <= LAST;
            end
            BWD: begin
               if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
